// File: rtl/segment7_pkg.sv
// Shared constants and hex decode for the 7-segment display blocks.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package segment7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      return SEG_TABLE[nibble];
   endfunction

endpackage

// File: rtl/segment7.sv
// Single-digit hex to active-low 7-segment decoder.
// Combinational; the owner registers the result.
module segment7
   import segment7_pkg::*;
(
   input  logic       i_enable,
   input  logic [3:0] i_hex,
   output logic [6:0] o_seg
);

   assign o_seg = i_enable ? hex_to_seg(i_hex) : SEG_BLANK;

endmodule

// File: rtl/segment7_mux.sv
// Time-multiplexed driver for DIGITS common-anode 7-segment digits,
// with decimal points, leading-zero suppression and registered outputs.
module segment7_mux
   import segment7_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     dp,
   input  logic                  lz_en,
   output logic [6:0]            seg,
   output logic                  dot,
   output logic [DIGITS-1:0]     an
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic [CW-1:0]     r_cnt;
   logic [IW-1:0]     r_idx;
   logic [3:0]        w_nib;
   logic              w_dp;
   logic              w_supp;
   logic [DIGITS-1:0] w_hi_zero;
   logic [DIGITS-1:0] w_an;
   logic [6:0]        w_seg;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (r_cnt == CW'(REFRESH_DIV - 1)) begin
         r_cnt <= '0;
         if (r_idx == IW'(DIGITS - 1))
            r_idx <= '0;
         else
            r_idx <= r_idx + IW'(1);
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // w_hi_zero[i]: nibble i and every nibble above it are zero
   always_comb begin
      logic v_z;
      v_z       = 1'b1;
      w_hi_zero = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         v_z          = v_z & (data[4*i +: 4] == 4'h0);
         w_hi_zero[i] = v_z;
      end
   end

   always_comb begin
      w_nib  = 4'h0;
      w_dp   = 1'b0;
      w_supp = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_idx == IW'(i)) begin
            w_nib  = data[4*i +: 4];
            w_dp   = dp[i];
            w_supp = lz_en && (i != 0) && w_hi_zero[i];
         end
      end
   end

   assign w_an = ~(DIGITS'(1) << r_idx);

   segment7 u_dec (
      .i_enable (1'b1),
      .i_hex    (w_nib),
      .o_seg    (w_seg)
   );

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         seg <= SEG_BLANK;
         dot <= 1'b1;
         an  <= '1;
      end else begin
         seg <= w_supp ? SEG_BLANK : w_seg;
         dot <= ~w_dp;
         an  <= w_an;
      end
   end

endmodule

// File: tb/tb_segment7_mux.sv
// Self-checking bench: three parameterisations of segment7_mux checked
// every cycle against a slot-arithmetic model plus directed literals.
module tb_segment7_mux;

   typedef struct packed {
      logic [6:0]  seg;
      logic        dot;
      logic [15:0] an;
   } out_t;

   localparam out_t BLANK = '{seg: 7'h7F, dot: 1'b1, an: 16'hFFFF};

   logic [6:0] SEGTAB [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   logic clk, rst, en, lz;
   logic [15:0] dA;
   logic [3:0]  dpA, anA;
   logic [3:0]  dB;
   logic        dpB, anB;
   logic [11:0] dC;
   logic [2:0]  dpC, anC;
   logic [6:0]  segA, segB, segC;
   logic        dotA, dotB, dotC;

   int n_tests = 0;
   int n_fail  = 0;

   segment7_mux #(.DIGITS(4), .REFRESH_DIV(4)) u_a (
      .clk(clk), .rst(rst), .enable(en), .data(dA), .dp(dpA),
      .lz_en(lz), .seg(segA), .dot(dotA), .an(anA));

   segment7_mux #(.DIGITS(1), .REFRESH_DIV(1)) u_b (
      .clk(clk), .rst(rst), .enable(en), .data(dB), .dp(dpB),
      .lz_en(lz), .seg(segB), .dot(dotB), .an(anB));

   segment7_mux #(.DIGITS(3), .REFRESH_DIV(2)) u_c (
      .clk(clk), .rst(rst), .enable(en), .data(dC), .dp(dpC),
      .lz_en(lz), .seg(segC), .dot(dotC), .an(anC));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected registered outputs for a digit index, from the display rules
   function automatic out_t model(input int d, input int idx,
                                  input logic [63:0] data, input logic [15:0] dpv,
                                  input logic lzv, input logic env);
      out_t o;
      logic [63:0] hi;
      o = BLANK;
      if (env) begin
         hi    = data >> (4 * idx);
         o.an  = ~(16'd1 << idx);
         o.dot = ~dpv[idx];
         if (lzv && idx != 0 && hi == 64'd0)
            o.seg = 7'h7F;
         else
            o.seg = SEGTAB[int'(hi[3:0])];
      end
      return o;
   endfunction

   out_t eA, eB, eC;
   int   tA, tB, tC;
   logic vld = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         eA <= BLANK; eB <= BLANK; eC <= BLANK;
         tA <= 0; tB <= 0; tC <= 0;
         vld <= 1'b1;
      end else begin
         eA <= model(4, (tA / 4) % 4, 64'(dA), 16'(dpA), lz, en);
         eB <= model(1, 0, 64'(dB), 16'(dpB), lz, en);
         eC <= model(3, (tC / 2) % 3, 64'(dC), 16'(dpC), lz, en);
         tA <= tA + 1; tB <= tB + 1; tC <= tC + 1;
      end
   end

   always @(negedge clk) begin
      if (vld) begin
         check("A_seg", 32'(segA), 32'(eA.seg));
         check("A_dot", 32'(dotA), 32'(eA.dot));
         check("A_an",  32'(anA),  32'(eA.an[3:0]));
         check("B_seg", 32'(segB), 32'(eB.seg));
         check("B_dot", 32'(dotB), 32'(eB.dot));
         check("B_an",  32'(anB),  32'(eB.an[0]));
         check("C_seg", 32'(segC), 32'(eC.seg));
         check("C_dot", 32'(dotC), 32'(eC.dot));
         check("C_an",  32'(anC),  32'(eC.an[2:0]));
      end
   end

   // Random data on the small instances, with leading zeros now and then
   initial begin
      dB = 4'h0; dpB = 1'b0; dC = 12'h0; dpC = 3'b0;
      forever begin
         @(negedge clk);
         dB  = 4'($urandom);
         dpB = 1'($urandom);
         dC  = 12'($urandom) >> (4 * $urandom_range(0, 3));
         dpC = 3'($urandom);
      end
   end

   task automatic wait_an(input logic [3:0] v);
      int k;
      k = 0;
      while (anA !== v && k < 64) begin
         @(negedge clk);
         k++;
      end
      if (anA !== v) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_an: got %b expected %b (timeout)", anA, v);
      end
   endtask

   logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [6:0] exp_seg [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

   initial begin
      rst = 1'b1; en = 1'b1; lz = 1'b0;
      dA = 16'h1234; dpA = 4'b0000;
      repeat (2) @(negedge clk);
      check("rst_seg", 32'(segA), 32'h7F);
      check("rst_dot", 32'(dotA), 32'h1);
      check("rst_an",  32'(anA),  32'hF);
      rst = 1'b0;

      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("sweep_an", 32'(anA), 32'(exp_an[s]));
         end
         check("sweep_seg", 32'(segA), 32'(exp_seg[s]));
         check("sweep_dot", 32'(dotA), 32'h1);
      end
      @(negedge clk);
      check("wrap_an", 32'(anA), 32'(4'b1110));
      check("B_an_lit", 32'(anB), 32'h0);

      for (int v = 0; v < 16; v++) begin
         dA = 16'(v);
         @(negedge clk);
         wait_an(4'b1110);
         check("table_seg", 32'(segA), 32'(SEGTAB[v]));
         repeat (4) @(negedge clk);
      end

      dA = 16'h0050; lz = 1'b1; dpA = 4'b1000;
      @(negedge clk);
      wait_an(4'b0111);
      check("lz_d3_seg", 32'(segA), 32'h7F);
      check("lz_d3_dot", 32'(dotA), 32'h0);
      wait_an(4'b1110);
      check("lz_d0_seg", 32'(segA), 32'(7'b1000000));
      wait_an(4'b1011);
      check("lz_d2_seg", 32'(segA), 32'h7F);
      wait_an(4'b1101);
      check("lz_d1_seg", 32'(segA), 32'(7'b0010010));
      dA = 16'h0000;
      @(negedge clk);
      wait_an(4'b1110);
      check("lz0_d0_seg", 32'(segA), 32'(7'b1000000));
      wait_an(4'b1101);
      check("lz0_d1_seg", 32'(segA), 32'h7F);

      lz = 1'b0; dA = 16'hABCD; dpA = 4'b0101;
      wait_an(4'b1011);
      en = 1'b0;
      @(negedge clk);
      check("dis_an",  32'(anA),  32'hF);
      check("dis_seg", 32'(segA), 32'h7F);
      check("dis_dot", 32'(dotA), 32'h1);
      repeat (5) @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      check("reen_an", 32'(anA), 32'(4'b0111));

      wait_an(4'b0111);
      rst = 1'b1;
      @(negedge clk);
      check("mrst_an", 32'(anA), 32'hF);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("mrst_slot", 32'(anA), 32'(4'b1110));
      end
      @(negedge clk);
      check("mrst_next", 32'(anA), 32'(4'b1101));

      repeat (20) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
